alu_issue_ctrl: RTL

Sequential issue controller that drives the 8-bit ALU from the instruction side. Accepts one 16-bit instruction per handshake, reads two operands from a local 4x8 register file, presents them with the opcode to the ALU, captures result and carry, writes back and updates flags. It sits between the instruction source and the combinational `alu8`, whose `A`, `B`, `sel`, `c_in`, `Y` and `C` ports connect directly to this block's `alu_*` ports.

---
 rtl/alu_issue_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Sequential issue controller for the 8-bit ALU: fetches operands from a local
// 4x8 register file, drives the ALU, captures its result and writes back.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    input  logic        host_we,
    input  logic [1:0]  host_addr,
    input  logic [7:0]  host_data,
    input  logic [1:0]  dbg_addr,
    output logic [7:0]  dbg_data,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_sel,
    output logic        alu_cin,
    input  logic [7:0]  alu_y,
    input  logic        alu_c,
    output logic        done,
    output logic        err,
    output logic        flag_c,
    output logic        flag_z
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_NAND = 4'h4,
        OP_NOR  = 4'h5,
        OP_NOT  = 4'h6,
        OP_XOR  = 4'h7,
        OP_XNOR = 4'h8
    } op_e;

    state_e      state;
    state_e      state_nxt;
    logic        rdy_q;

    logic [7:0]  regs [4];

    logic [3:0]  op_q;
    logic [1:0]  rd_q;
    logic [1:0]  rs1_q;
    logic [1:0]  rs2_q;
    logic        use_c_q;

    logic [7:0]  res_y_q;
    logic        res_c_q;

    logic        accept;
    logic        op_legal;
    logic        op_sets_c;
    logic        cin_nxt;
    logic        unused_reserved;

    // Reserved instruction bits carry no meaning for this block.
    assign unused_reserved = ^in_instr[4:0];

    // Ready is registered so it stays low throughout reset and rises on the
    // first edge that samples rst_n high.
    assign in_ready = rdy_q;
    assign accept   = in_valid && rdy_q;
    assign dbg_data = regs[dbg_addr];

    assign op_legal  = (op_q <= OP_XNOR);
    assign op_sets_c = (op_q == OP_ADD) || (op_q == OP_SUB);

    always_comb begin
        cin_nxt = 1'b0;
        if (op_q == OP_ADD) begin
            cin_nxt = use_c_q ? flag_c : 1'b0;
        end else if (op_q == OP_SUB) begin
            cin_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt == ST_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            use_c_q <= 1'b0;
            res_y_q <= '0;
            res_c_q <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            alu_cin <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // A host write and an accept in the same IDLE cycle both land;
            // READ samples the register file one edge later and sees the write.
            if (state == ST_IDLE && host_we) begin
                regs[host_addr] <= host_data;
            end

            if (state == ST_IDLE && accept) begin
                op_q    <= in_instr[15:12];
                rd_q    <= in_instr[11:10];
                rs1_q   <= in_instr[9:8];
                rs2_q   <= in_instr[7:6];
                use_c_q <= in_instr[5];
            end

            if (state == ST_READ) begin
                alu_a   <= regs[rs1_q];
                alu_b   <= regs[rs2_q];
                alu_sel <= op_q;
                alu_cin <= cin_nxt;
            end

            if (state == ST_EXEC) begin
                res_y_q <= alu_y;
                res_c_q <= alu_c;
            end

            if (state == ST_WB) begin
                done <= 1'b1;
                err  <= !op_legal;
                if (op_legal) begin
                    regs[rd_q] <= res_y_q;
                    flag_z     <= (res_y_q == 8'h00);
                    if (op_sets_c) begin
                        flag_c <= res_c_q;
                    end
                end
            end
        end
    end

endmodule
